boid_frame_sched: RTL and testbench



---
 rtl/boid_pkg.sv | 19 +
 rtl/boid_nbr_step.sv | 32 +++
 rtl/boid_frame_sched.sv | 148 ++++++++++++++
 tb/tb_boid_frame_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// Shared types and helpers for the boid frame scheduler.
package boid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELF_RD = 3'd1,
    NBR_RD  = 3'd2,
    CALC    = 3'd3,
    WB      = 3'd4,
    DONE    = 3'd5
  } sched_state_t;

  localparam int BOID_NUM_DEFAULT = 2;

  function automatic int boid_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boid_nbr_step.sv
// Neighbour index stepping: first index != self, next index skipping self,
// and whether the current neighbour is the last one for this self.
module boid_nbr_step
  import boid_pkg::*;
#(
  parameter int NUM_BOIDS = BOID_NUM_DEFAULT,
  parameter int IDX_W     = boid_idx_w(NUM_BOIDS)
) (
  input  logic [IDX_W-1:0] self_idx,
  input  logic [IDX_W-1:0] nbr_idx,
  output logic [IDX_W-1:0] first_nbr,
  output logic [IDX_W-1:0] next_nbr,
  output logic             is_last
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BOIDS - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] ZERO = '0;

  logic [IDX_W-1:0] last_nbr;
  logic [IDX_W-1:0] inc_nbr;

  always_comb begin
    first_nbr = (self_idx == ZERO) ? ONE : ZERO;
    last_nbr  = (self_idx == LAST) ? (LAST - ONE) : LAST;
    is_last   = (nbr_idx == last_nbr);
    inc_nbr   = nbr_idx + ONE;
    // Only meaningful when !is_last, so the skip never runs past LAST.
    next_nbr  = (inc_nbr == self_idx) ? (inc_nbr + ONE) : inc_nbr;
  end

endmodule

// File: rtl/boid_frame_sched.sv
// Per-frame boid scheduler: self read, neighbour reads + accumulate, write-back.
// Optional BOID_SCHED_PERF_EN adds a saturating frame_cycles counter port.
//
// state   | meaning
// IDLE    | waiting for start
// SELF_RD | reading self boid, clear accumulators on ack
// NBR_RD  | reading current neighbour boid
// CALC    | one-cycle accumulate of self/neighbour pair
// WB      | writing self back to the store
// DONE    | one-cycle end-of-frame pulse
module boid_frame_sched
  import boid_pkg::*;
#(
  parameter  int NUM_BOIDS = BOID_NUM_DEFAULT,
  localparam int IDX_W     = boid_idx_w(NUM_BOIDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_req,
  output logic [IDX_W-1:0] rd_addr,
  output logic             rd_sel,
  input  logic             rd_ack,
  output logic             dp_clr,
  output logic             dp_en,
  output logic             wr_req,
  output logic [IDX_W-1:0] wr_addr,
  input  logic             wr_ack,
  output logic [IDX_W-1:0] self_idx
`ifdef BOID_SCHED_PERF_EN
  ,
  output logic [31:0]      frame_cycles
`endif
);

  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_BOIDS - 1);
  localparam bit               SINGLE = (NUM_BOIDS == 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] self_q, self_d;
  logic [IDX_W-1:0] nbr_q, nbr_d;
  logic [IDX_W-1:0] first_nbr, next_nbr;
  logic             is_last;

  boid_nbr_step #(
    .NUM_BOIDS (NUM_BOIDS),
    .IDX_W     (IDX_W)
  ) u_nbr_step (
    .self_idx  (self_q),
    .nbr_idx   (nbr_q),
    .first_nbr (first_nbr),
    .next_nbr  (next_nbr),
    .is_last   (is_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      self_q  <= '0;
      nbr_q   <= '0;
    end else begin
      state_q <= state_d;
      self_q  <= self_d;
      nbr_q   <= nbr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    self_d  = self_q;
    nbr_d   = nbr_q;
    done    = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
    rd_sel  = 1'b0;
    dp_clr  = 1'b0;
    dp_en   = 1'b0;
    wr_req  = 1'b0;
    wr_addr = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SELF_RD;
          self_d  = '0;
        end
      end
      SELF_RD: begin
        rd_req  = 1'b1;
        rd_addr = self_q;
        if (rd_ack) begin
          dp_clr  = 1'b1;
          nbr_d   = first_nbr;
          state_d = SINGLE ? WB : NBR_RD;
        end
      end
      NBR_RD: begin
        rd_req  = 1'b1;
        rd_addr = nbr_q;
        rd_sel  = 1'b1;
        if (rd_ack) state_d = CALC;
      end
      CALC: begin
        dp_en = 1'b1;
        if (is_last) begin
          state_d = WB;
        end else begin
          nbr_d   = next_nbr;
          state_d = NBR_RD;
        end
      end
      WB: begin
        wr_req  = 1'b1;
        wr_addr = self_q;
        if (wr_ack) begin
          if (self_q == LAST) begin
            state_d = DONE;
          end else begin
            self_d  = self_q + IDX_W'(1);
            state_d = SELF_RD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign self_idx = self_q;

`ifdef BOID_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cycles <= '0;
    end else if (state_q == IDLE) begin
      if (start) frame_cycles <= '0;
    end else if (frame_cycles != 32'hFFFF_FFFF) begin
      frame_cycles <= frame_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_boid_frame_sched.sv
// Directed bench for boid_frame_sched with N=2, N=4 and N=1 instances.
module tb_boid_frame_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // N=2 instance
  logic start2 = 1'b0, rd_ack2 = 1'b0, wr_ack2 = 1'b0;
  logic busy2, done2, rd_req2, rd_sel2, dp_clr2, dp_en2, wr_req2;
  logic [0:0] rd_addr2, wr_addr2, self_idx2;
  // N=4 instance
  logic start4 = 1'b0, rd_ack4 = 1'b0, wr_ack4 = 1'b0;
  logic busy4, done4, rd_req4, rd_sel4, dp_clr4, dp_en4, wr_req4;
  logic [1:0] rd_addr4, wr_addr4, self_idx4;
  // N=1 instance
  logic start1 = 1'b0, rd_ack1 = 1'b0, wr_ack1 = 1'b0;
  logic busy1, done1, rd_req1, rd_sel1, dp_clr1, dp_en1, wr_req1;
  logic [0:0] rd_addr1, wr_addr1, self_idx1;
`ifdef BOID_SCHED_PERF_EN
  logic [31:0] frame_cycles2, frame_cycles4, frame_cycles1;
`endif

  boid_frame_sched #(.NUM_BOIDS(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_sel(rd_sel2), .rd_ack(rd_ack2),
    .dp_clr(dp_clr2), .dp_en(dp_en2), .wr_req(wr_req2), .wr_addr(wr_addr2),
    .wr_ack(wr_ack2), .self_idx(self_idx2)
`ifdef BOID_SCHED_PERF_EN
    , .frame_cycles(frame_cycles2)
`endif
  );

  boid_frame_sched #(.NUM_BOIDS(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .rd_req(rd_req4), .rd_addr(rd_addr4), .rd_sel(rd_sel4), .rd_ack(rd_ack4),
    .dp_clr(dp_clr4), .dp_en(dp_en4), .wr_req(wr_req4), .wr_addr(wr_addr4),
    .wr_ack(wr_ack4), .self_idx(self_idx4)
`ifdef BOID_SCHED_PERF_EN
    , .frame_cycles(frame_cycles4)
`endif
  );

  boid_frame_sched #(.NUM_BOIDS(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_sel(rd_sel1), .rd_ack(rd_ack1),
    .dp_clr(dp_clr1), .dp_en(dp_en1), .wr_req(wr_req1), .wr_addr(wr_addr1),
    .wr_ack(wr_ack1), .self_idx(self_idx1)
`ifdef BOID_SCHED_PERF_EN
    , .frame_cycles(frame_cycles1)
`endif
  );

  // {busy, rd_req, rd_addr, rd_sel, dp_clr, dp_en, wr_req, wr_addr, done};
  // addresses/sel are masked to 0 when their request is low.
  function automatic logic [8:0] obs2();
    return {busy2, rd_req2, rd_req2 & rd_addr2[0], rd_req2 & rd_sel2,
            dp_clr2, dp_en2, wr_req2, wr_req2 & wr_addr2[0], done2};
  endfunction

  function automatic logic [8:0] obs1();
    return {busy1, rd_req1, rd_req1 & rd_addr1[0], rd_req1 & rd_sel1,
            dp_clr1, dp_en1, wr_req1, wr_req1 & wr_addr1[0], done1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (start was sampled at the end of cycle 0).
  task automatic kick2();
    step();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests++;
    if (obs2() !== 9'd0 || self_idx2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_n2: got %b self=%0d, want 0", obs2(), self_idx2);
    end
    tests++;
    if ({busy4, done4, rd_req4, dp_clr4, dp_en4, wr_req4} !== 6'd0 || self_idx4 !== 2'd0) begin
      fails++;
      $display("FAIL reset_n4: got busy=%b done=%b rd=%b wr=%b self=%0d, want 0",
               busy4, done4, rd_req4, wr_req4, self_idx4);
    end
    tests++;
    if (obs1() !== 9'd0) begin
      fails++;
      $display("FAIL reset_n1: got %b, want 0", obs1());
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_n2_zero_wait();
    logic [8:0] exp [10] = '{9'b110010000, 9'b111100000, 9'b100001000, 9'b100000100,
                             9'b111010000, 9'b110100000, 9'b100001000, 9'b100000110,
                             9'b100000001, 9'b000000000};
    rd_ack2 = 1'b1;
    wr_ack2 = 1'b1;
    kick2();
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      tests++;
      if (obs2() !== exp[c-1]) begin
        fails++;
        $display("FAIL n2_seq cycle %0d: got %b, want %b", c, obs2(), exp[c-1]);
      end
    end
`ifdef BOID_SCHED_PERF_EN
    tests++;
    if (frame_cycles2 !== 32'd9) begin
      fails++;
      $display("FAIL n2_frame_cycles: got %0d, want 9", frame_cycles2);
    end
`endif
  endtask

  task automatic test_n4_self2();
    int q[$];
    int exp [7] = '{0, 100, 1, 100, 3, 100, 202};
    int done_cyc = 0;
    rd_ack4 = 1'b1;
    wr_ack4 = 1'b1;
    step();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (c > 1) step();
      if (done4) done_cyc = c;
      if (self_idx4 == 2'd2 && busy4) begin
        if (rd_req4 && rd_sel4) q.push_back(int'(rd_addr4));
        if (dp_en4) q.push_back(100);
        if (wr_req4) q.push_back(200 + int'(wr_addr4));
      end
    end
    tests++;
    if (done_cyc != 33) begin
      fails++;
      $display("FAIL n4_done_cycle: got %0d, want 33", done_cyc);
    end
    tests++;
    if (q.size() != 7) begin
      fails++;
      $display("FAIL n4_self2_events: got %0d events, want 7", q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests++;
        if (q[i] != exp[i]) begin
          fails++;
          $display("FAIL n4_self2_event %0d: got %0d, want %0d", i, q[i], exp[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_rd_wait();
    int cnt = 0;
    int done_cyc = 0;
    int stable_checks = 0;
    logic prev_ack = 1'b0;
    logic [1:0] held = '0;
    rd_ack2 = 1'b0;
    wr_ack2 = 1'b1;
    kick2();
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) step();
      if (prev_ack) cnt = 0;
      if (done2 && done_cyc == 0) done_cyc = c;
      if (rd_req2) begin
        if (cnt == 0) begin
          held = {rd_addr2[0], rd_sel2};
        end else begin
          stable_checks++;
          tests++;
          if ({rd_addr2[0], rd_sel2} !== held) begin
            fails++;
            $display("FAIL rd_wait_stable cycle %0d: got %b, want %b", c,
                     {rd_addr2[0], rd_sel2}, held);
          end
        end
        cnt++;
        rd_ack2 = (cnt == 4);
      end else begin
        cnt = 0;
        rd_ack2 = 1'b0;
      end
      prev_ack = rd_ack2;
    end
    rd_ack2 = 1'b0;
    tests++;
    if (done_cyc != 21) begin
      fails++;
      $display("FAIL rd_wait_done_cycle: got %0d, want 21", done_cyc);
    end
    tests++;
    if (stable_checks != 12) begin
      fails++;
      $display("FAIL rd_wait_count: got %0d wait cycles, want 12", stable_checks);
    end
  endtask

  task automatic test_reset_mid();
    int done_cyc = 0;
    rd_ack2 = 1'b1;
    wr_ack2 = 1'b1;
    kick2();
    repeat (5) step();
    tests++;
    if ({rd_req2, rd_sel2, self_idx2[0]} !== 3'b111) begin
      fails++;
      $display("FAIL reset_mid_pre: got rd_req=%b sel=%b self=%0d, want 1 1 1",
               rd_req2, rd_sel2, self_idx2);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (obs2() !== 9'd0 || self_idx2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_post: got %b self=%0d, want 0", obs2(), self_idx2);
    end
    kick2();
    tests++;
    if (obs2() !== 9'b110010000 || self_idx2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_restart: got %b self=%0d, want 110010000 self=0",
               obs2(), self_idx2);
    end
    for (int c = 2; c <= 20 && done_cyc == 0; c++) begin
      step();
      if (done2) done_cyc = c;
    end
    tests++;
    if (done_cyc != 9) begin
      fails++;
      $display("FAIL reset_mid_done: got cycle %0d, want 9", done_cyc);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    int done_cyc = 0;
    rd_ack2 = 1'b1;
    wr_ack2 = 1'b1;
    kick2();
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) step();
      if (done2) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      start2 = (c == 3 || c == 9);
    end
    start2 = 1'b0;
    tests++;
    if (done_cnt != 1 || done_cyc != 9) begin
      fails++;
      $display("FAIL start_ignored_done: got %0d dones first at %0d, want 1 at 9",
               done_cnt, done_cyc);
    end
    tests++;
    if (busy2 !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored_idle: got busy=%b, want 0", busy2);
    end
  endtask

  task automatic test_n1();
    logic [8:0] exp [4] = '{9'b110010000, 9'b100000100, 9'b100000001, 9'b000000000};
    int en_cnt = 0;
    rd_ack1 = 1'b1;
    wr_ack1 = 1'b1;
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      if (dp_en1) en_cnt++;
      if (c <= 4) begin
        tests++;
        if (obs1() !== exp[c-1]) begin
          fails++;
          $display("FAIL n1_seq cycle %0d: got %b, want %b", c, obs1(), exp[c-1]);
        end
      end
`ifdef BOID_SCHED_PERF_EN
      if (c == 4) begin
        tests++;
        if (frame_cycles1 !== 32'd3) begin
          fails++;
          $display("FAIL n1_frame_cycles: got %0d, want 3", frame_cycles1);
        end
      end
`endif
    end
    tests++;
    if (en_cnt != 0) begin
      fails++;
      $display("FAIL n1_dp_en: got %0d pulses, want 0", en_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_n2_zero_wait();
    test_n4_self2();
    test_rd_wait();
    test_reset_mid();
    test_start_ignored();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
